// File: rtl/ram_stream_pkg.sv
// ---------------------------------------------------------------------------
// ram_stream_pkg
// Shared definitions for the RAM stream reader slice: default widths of the
// RAM / stream interfaces, skid buffer depth and the reader FSM state type.
// No ports (package only).
// ---------------------------------------------------------------------------
package ram_stream_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 13;

  // Two entries are enough to cover the one-cycle RAM latency plus one word
  // held back by downstream backpressure.
  localparam int BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_skid_buf.sv
// ---------------------------------------------------------------------------
// ram_skid_buf
// Two-entry FIFO that catches RAM read data (plus its sop/eop tags) and
// presents it to the stream side with valid/ready handshaking.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 drop every stored entry (synchronous)
//   wr_en, wr_data        capture strobe and word {sop, eop, data}
//   rd_valid, rd_ready    head-of-queue handshake
//   rd_data               head-of-queue word
//   occupancy             number of stored entries (0..2)
// ---------------------------------------------------------------------------
module ram_skid_buf
  import ram_stream_pkg::*;
#(
  parameter int W = DATA_W_DEF + 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] r_mem [BUF_DEPTH];
  logic         r_wrPtr;
  logic         r_rdPtr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign rd_valid  = (r_count != 2'd0);
  assign rd_data   = r_mem[r_rdPtr];
  assign occupancy = r_count;
  assign w_pop     = rd_valid & rd_ready;

  // Storage and pointers. The writer never pushes into a full buffer (the
  // reader only issues a read when a slot is guaranteed), so a simultaneous
  // push and pop simply keeps the count while preserving order. Flush wins
  // over any capture in the same cycle so an aborted read is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (wr_en) begin
        r_mem[r_wrPtr] <= wr_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, wr_en} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Avalon-MM read master for the 4096x32 single-port SOC RAM. Turns a
// (base, length) request into an Avalon-ST packet with sop/eop framing.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start, base_addr, length          request (sampled only while idle)
//   abort                             flush the current transfer
//   busy, done                        transfer status / completion pulse
//   ram_address, ram_chipselect       read issue towards the RAM
//   ram_write, ram_byteenable,
//   ram_clken                         tied-off RAM controls
//   ram_readdata                      RAM q, valid one cycle after issue
//   src_data, src_valid, src_ready,
//   src_sop, src_eop                  Avalon-ST source
// ---------------------------------------------------------------------------
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_infSop;
  logic              r_infEop;
  logic              r_first;
  logic              r_done;

  logic              w_busy;
  logic              w_abort;
  logic              w_pop;
  logic              w_issue;
  logic              w_lastIssue;
  logic              w_eopHs;
  logic              w_headValid;
  logic [1:0]        w_occ;
  logic [2:0]        w_outstanding;
  logic [DATA_W+1:0] w_head;
  logic [DATA_W+1:0] w_capture;

  assign w_busy  = (r_state != IDLE);
  assign w_abort = abort & w_busy;
  assign w_pop   = w_headValid & src_ready;
  assign w_eopHs = w_pop & w_head[DATA_W];

  // Words that will still be held (buffered or in flight) after this cycle's
  // pop. Counting the pop keeps one word per cycle flowing when the sink is
  // always ready, while never letting a capture find the buffer full.
  assign w_outstanding = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};

  assign w_issue     = (r_state == RUN) && (r_remaining != '0) &&
                       (w_outstanding < DEPTH) && !w_abort;
  assign w_lastIssue = w_issue && (r_remaining == LEN_W'(1));

  // Framing tags travel with the read so the buffer carries them alongside
  // the data; the capture itself never waits on the sink.
  assign w_capture = {r_infSop, r_infEop, ram_readdata};

  ram_skid_buf #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_abort),
    .wr_en     (r_inflight),
    .wr_data   (w_capture),
    .rd_valid  (w_headValid),
    .rd_ready  (src_ready),
    .rd_data   (w_head),
    .occupancy (w_occ)
  );

  assign busy           = w_busy;
  assign done           = r_done;
  assign ram_address    = r_addr;
  assign ram_chipselect = w_issue;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign src_valid      = w_headValid;
  assign src_data       = w_head[DATA_W-1:0];
  assign src_sop        = w_headValid & w_head[DATA_W+1];
  assign src_eop        = w_headValid & w_head[DATA_W];

  // Control FSM with the address/remaining counters and the in-flight tag.
  // The issue bookkeeping runs first; the state case then overrides the
  // counters on a new request or an abort. Done is a single-cycle pulse for
  // a normal finish, an empty request, or an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_infSop    <= 1'b0;
      r_infEop    <= 1'b0;
      r_first     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
        r_infSop    <= r_first;
        r_infEop    <= w_lastIssue;
        r_first     <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_addr      <= base_addr;
              r_remaining <= length;
              r_first     <= 1'b1;
              r_state     <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_abort) begin
            r_remaining <= '0;
            r_state     <= IDLE;
            r_done      <= 1'b1;
          end else if (w_lastIssue) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_abort || w_eopHs) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
// Scoreboard bench for ram_stream_reader with a behavioural one-cycle RAM.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [11:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic        ram_clken;
  logic [31:0] ram_readdata = '0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        src_sop;
  logic        src_eop;

  logic [31:0] mem [4096];
  exp_t        sbq[$];
  logic [11:0] addrq[$];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycle      = 0;
  int readyMode  = 0;
  int patIdx     = 0;
  bit readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int firstValid, eopCycle, doneCycle, doneCount;
  int sopCount, eopCount, hsCount, outstanding;
  bit busySeen, validSeen;
  bit prevStall;
  logic [33:0] prevWord;

  ram_stream_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_sop        (src_sop),
    .src_eop        (src_eop)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure latencies between events.
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural single-port RAM: registered q, one cycle after the issue.
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken && !ram_write) ram_readdata <= mem[ram_address];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input logic [63:0] actual);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, actual);
  endtask

  // Sink readiness: always ready, a fixed stall pattern, or random.
  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        1: begin
          src_ready = readyPat[patIdx];
          patIdx    = (patIdx + 1) % 6;
        end
        2: src_ready = 1'($urandom_range(0, 1));
        default: src_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks issued addresses, outstanding words, stall stability and
  // stream words against the scoreboard queues; records timing of events.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busySeen = 1'b1;
      if (src_valid) validSeen = 1'b1;
      if (done) begin
        doneCount++;
        doneCycle = cycle;
      end
      if (src_valid && firstValid < 0) firstValid = cycle;
      if (prevStall)
        checkOutput("stall hold", 64'({src_valid, src_sop, src_eop, src_data}), 64'({1'b1, prevWord}));
      prevStall = src_valid && !src_ready;
      prevWord  = {src_sop, src_eop, src_data};
      outstanding += int'(ram_chipselect) - int'(src_valid && src_ready);
      if (ram_chipselect) begin
        if (addrq.size() == 0) failNow("unexpected issue", 64'(ram_address));
        else checkOutput("ram_address", 64'(ram_address), 64'(addrq.pop_front()));
        checkOutput("outstanding le 2", 64'(outstanding <= 2), 64'd1);
      end
      if (src_valid && src_ready) begin
        hsCount++;
        if (src_sop) sopCount++;
        if (src_eop) begin
          eopCount++;
          eopCycle = cycle;
        end
        if (sbq.size() == 0) failNow("unexpected word", 64'(src_data));
        else checkOutput("stream word", 64'({src_data, src_sop, src_eop}), 64'(sbq.pop_front()));
      end
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic clearStats();
    firstValid = -1; eopCycle = -1; doneCycle = -1; doneCount = 0;
    sopCount = 0; eopCount = 0; hsCount = 0;
    busySeen = 1'b0; validSeen = 1'b0;
  endtask

  task automatic pushExpected(input logic [11:0] b, input int len);
    logic [11:0] a;
    exp_t e;
    a = b;
    for (int i = 0; i < len; i++) begin
      addrq.push_back(a);
      e.data = 32'hA000_0000 + 32'(a);
      e.sop  = (i == 0);
      e.eop  = (i == len - 1);
      sbq.push_back(e);
      a = a + 12'd1;
    end
  endtask

  task automatic pulseStart(input logic [11:0] b, input logic [12:0] len, output int startCycle);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = len;
    @(posedge clk); #1;
    start = 1'b0;
    startCycle = cycle;
  endtask

  // One complete request: queue expectations, start, wait for done, check.
  task automatic applyStimulus(input logic [11:0] b, input logic [12:0] len, input int mode);
    int startCycle;
    int budget;
    readyMode = mode;
    clearStats();
    pushExpected(b, int'(len));
    pulseStart(b, len, startCycle);
    budget = 4 * int'(len) + 40;
    while (doneCount == 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (doneCount == 0) begin
      failNow("done timeout", 64'(len));
    end else if (len == 0) begin
      checkOutput("len0 done latency", 64'(doneCycle), 64'(startCycle));
      checkOutput("len0 busy never", 64'(busySeen), 64'd0);
      checkOutput("len0 valid never", 64'(validSeen), 64'd0);
    end else begin
      checkOutput("done after eop", 64'(doneCycle), 64'(eopCycle + 1));
      checkOutput("busy low with done", 64'(busy), 64'd0);
      checkOutput("busy seen", 64'(busySeen), 64'd1);
      checkOutput("sop count", 64'(sopCount), 64'd1);
      checkOutput("eop count", 64'(eopCount), 64'd1);
      checkOutput("word count", 64'(hsCount), 64'(len));
      checkOutput("scoreboard empty", 64'(sbq.size()), 64'd0);
      checkOutput("addr queue empty", 64'(addrq.size()), 64'd0);
      if (mode == 0) begin
        checkOutput("first valid latency", 64'(firstValid), 64'(startCycle + 2));
        checkOutput("eop cycle", 64'(eopCycle), 64'(startCycle + int'(len) + 1));
      end
    end
    @(negedge clk); #1;
    checkOutput("done one cycle", 64'(done), 64'd0);
    checkOutput("busy idle", 64'(busy), 64'd0);
    checkOutput("done pulse count", 64'(doneCount), 64'd1);
    readyMode = 0;
  endtask

  initial begin
    int sc;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    #1;
    checkOutput("reset outputs",
      64'({busy, done, src_valid, src_sop, src_eop, ram_chipselect, ram_address, src_data}), 64'd0);
    checkOutput("tie-offs", 64'({ram_write, ram_byteenable, ram_clken}), 64'({1'b0, 4'hF, 1'b1}));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    outstanding = 0;

    $display("[TB] basic transfer");
    applyStimulus(12'h010, 13'd4, 0);
    $display("[TB] backpressure pattern");
    applyStimulus(12'h010, 13'd4, 1);
    $display("[TB] address wrap");
    applyStimulus(12'hFFE, 13'd4, 0);
    $display("[TB] zero and single length");
    applyStimulus(12'h020, 13'd0, 0);
    applyStimulus(12'h033, 13'd1, 0);

    $display("[TB] abort after two words");
    clearStats();
    pushExpected(12'h000, 8);
    pulseStart(12'h000, 13'd8, sc);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sbq.delete();
    addrq.delete();
    outstanding = 0;
    @(negedge clk); #1;
    checkOutput("abort valid drop", 64'(src_valid), 64'd0);
    checkOutput("abort done", 64'(done), 64'd1);
    checkOutput("abort busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("abort words taken", 64'(hsCount), 64'd2);
    checkOutput("abort no eop", 64'(eopCount), 64'd0);
    checkOutput("abort done once", 64'(doneCount), 64'd1);
    applyStimulus(12'h100, 13'd2, 0);

    $display("[TB] full RAM with random backpressure");
    applyStimulus(12'h000, 13'd4096, 2);

    $display("[TB] reset mid-transfer");
    clearStats();
    pushExpected(12'h200, 16);
    pulseStart(12'h200, 13'd16, sc);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid reset outputs",
      64'({busy, done, src_valid, src_sop, src_eop, ram_chipselect, ram_address, src_data}), 64'd0);
    sbq.delete();
    addrq.delete();
    outstanding = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(12'h010, 13'd4, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
